narma_system_top: RTL and testbench

// - Self-contained NARMA-10 benchmark generator. An internal LFSR produces the input u(t).
// - A fixed-point recurrence produces one new y(t) every clock.
// - y(t) is also emitted as a 32-bit thermometer bitstream for spiking/reservoir front ends.
// - Top of the NARMA stimulus path; merges the sequence generator and the bitstream converter.

---
 rtl/narma_system_top.sv | 123 ++++++++++++
 tb/tb_narma_system_top.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/narma_system_top.sv
// narma_system_top
// Self-contained NARMA-10 stimulus generator. A 16-bit LFSR supplies the
// input u(t). A fixed-point NARMA recurrence produces one new y(t) every
// clock. y(t) is also presented as a thermometer-coded bitstream for
// spiking or reservoir front ends.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low clear of all state
//   narma_output   registered y(t), unsigned Q6.10 (value = code/1024)
//   bitstream_out  thermometer code of narma_output, min(BS_W, y>>5) ones
module narma_system_top #(
  parameter int          DATA_W    = 16,
  parameter int          ORDER     = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          BS_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] narma_output,
  output logic [BS_W-1:0]   bitstream_out
);

  // Number of stored past samples: y(t-1)..y(t-ORDER+1), same depth for u.
  localparam int HIST   = ORDER - 1;
  localparam int SUM_W  = DATA_W + $clog2(ORDER);
  // Wide enough that y*s followed by the *51 scale can never overflow.
  localparam int MATH_W = DATA_W + SUM_W + 8;
  localparam int FRAC   = 32'd10;
  localparam int BS_SH  = 32'd5;

  // Q6.10 coefficients: 0.3, 0.05, 1.5 and the 0.1 offset.
  localparam logic [15:0] K_P1  = 16'd307;
  localparam logic [15:0] K_P2  = 16'd51;
  localparam logic [15:0] K_P3  = 16'd1536;
  localparam logic [15:0] K_OFS = 16'd102;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [MATH_W-1:0] Y_MAX = MATH_W'({DATA_W{1'b1}});

  logic [DATA_W-1:0] y_r;
  logic [DATA_W-1:0] y_hist_r [HIST];
  logic [DATA_W-1:0] u_hist_r [HIST];
  logic [15:0]       lfsr_r;

  logic              lfsr_fb_s;
  logic [DATA_W-1:0] u0_s;
  logic [MATH_W-1:0] sum_s;
  logic [MATH_W-1:0] p1_s;
  logic [MATH_W-1:0] p2_s;
  logic [MATH_W-1:0] p3_s;
  logic [DATA_W-1:0] y_next_s;

  // Clamp a wide non-negative result into the sample range.
  function automatic logic [DATA_W-1:0] sat_y(input logic [MATH_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > Y_MAX) begin
      r = {DATA_W{1'b1}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  // Thermometer code: bit i set when i < (v >> 5); saturates at all ones.
  function automatic logic [BS_W-1:0] therm(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] n;
    logic [BS_W-1:0]   r;
    n = v >> BS_SH;
    r = '0;
    for (int i = 0; i < BS_W; i++) begin
      if (n > DATA_W'(i)) begin
        r[i] = 1'b1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Input sample and LFSR feedback (taps 16,14,13,11).
  always_comb begin
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    u0_s      = {{(DATA_W-9){1'b0}}, lfsr_r[8:0]};
  end

  // NARMA recurrence with truncating Q6.10 rescaling after each product.
  always_comb begin
    sum_s = MATH_W'(y_r);
    for (int i = 0; i < HIST; i++) begin
      sum_s = sum_s + MATH_W'(y_hist_r[i]);
    end
    p1_s = (MATH_W'(y_r) * MATH_W'(K_P1)) >> FRAC;
    p2_s = (((MATH_W'(y_r) * sum_s) >> FRAC) * MATH_W'(K_P2)) >> FRAC;
    p3_s = (((MATH_W'(u0_s) * MATH_W'(u_hist_r[HIST-1])) >> FRAC) * MATH_W'(K_P3)) >> FRAC;
    y_next_s = sat_y(p1_s + p2_s + p3_s + MATH_W'(K_OFS));
  end

  // Sample, history and LFSR state; everything advances every clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_r      <= '0;
      y_hist_r <= '{default: '0};
      u_hist_r <= '{default: '0};
      lfsr_r   <= SEED_EFF;
    end else begin
      y_r         <= y_next_s;
      y_hist_r[0] <= y_r;
      u_hist_r[0] <= u0_s;
      for (int i = 1; i < HIST; i++) begin
        y_hist_r[i] <= y_hist_r[i-1];
        u_hist_r[i] <= u_hist_r[i-1];
      end
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end

  assign narma_output  = y_r;
  assign bitstream_out = therm(y_r);

endmodule

// File: tb/tb_narma_system_top.sv
module tb_narma_system_top;

  logic        clk;
  logic        reset;
  logic [15:0] narma_output;
  logic [31:0] bitstream_out;

  int n_cmp;
  int n_bad;

  narma_system_top dut (
    .clk           (clk),
    .reset         (reset),
    .narma_output  (narma_output),
    .bitstream_out (bitstream_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_v;
    logic [15:0] exp_y;
    logic [31:0] exp_bs;
  } vec_t;

  vec_t vecs [4];

  // Each row: drive reset at a falling edge, check at the next falling edge.
  task automatic run_vecs(input int first, input string tag);
    for (int i = first; i < 4; i++) begin
      reset = vecs[i].rst_v;
      @(negedge clk);
      check($sformatf("%s_y[%0d]", tag, i), {16'h0000, narma_output}, {16'h0000, vecs[i].exp_y});
      check($sformatf("%s_bs[%0d]", tag, i), bitstream_out, vecs[i].exp_bs);
    end
  endtask

  // Independent reference model of the generator.
  longint      m_y;
  longint      m_yh [9];
  longint      m_uh [9];
  logic [15:0] m_lfsr;
  longint      m_p3;

  task automatic model_reset();
    m_y    = 0;
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 9; k++) begin
      m_yh[k] = 0;
      m_uh[k] = 0;
    end
  endtask

  task automatic model_step();
    longint u0, s, p1, p2, yn;
    logic   fb;
    u0 = longint'(m_lfsr[8:0]);
    s  = m_y;
    for (int k = 0; k < 9; k++) s += m_yh[k];
    p1   = (307 * m_y) >> 10;
    p2   = (((m_y * s) >> 10) * 51) >> 10;
    m_p3 = (((u0 * m_uh[8]) >> 10) * 1536) >> 10;
    yn   = p1 + p2 + m_p3 + 102;
    if (yn > 65535) yn = 65535;
    for (int k = 8; k > 0; k--) begin
      m_yh[k] = m_yh[k-1];
      m_uh[k] = m_uh[k-1];
    end
    m_yh[0] = m_y;
    m_uh[0] = u0;
    m_y     = yn;
    fb      = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr  = {m_lfsr[14:0], fb};
  endtask

  function automatic logic [31:0] model_therm(input longint y);
    longint n;
    n = y / 32;
    if (n >= 32) return 32'hFFFF_FFFF;
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  initial begin
    int p3_first;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{rst_v: 1'b0, exp_y: 16'd0,   exp_bs: 32'h0000_0000};
    vecs[1] = '{rst_v: 1'b1, exp_y: 16'd102, exp_bs: 32'h0000_0007};
    vecs[2] = '{rst_v: 1'b1, exp_y: 16'd132, exp_bs: 32'h0000_000F};
    vecs[3] = '{rst_v: 1'b1, exp_y: 16'd142, exp_bs: 32'h0000_000F};

    // Reset held for 20 ns, released on the falling edge at 20 ns.
    reset = 1'b0;
    @(negedge clk);
    run_vecs(0, "start");

    // Fresh reset, then 100 samples against the reference model.
    reset = 1'b0;
    @(negedge clk);
    check("rst2_y", {16'h0000, narma_output}, 32'h0);
    reset = 1'b1;
    model_reset();
    p3_first = 0;
    for (int c = 1; c <= 100; c++) begin
      model_step();
      if (m_p3 != 0 && p3_first == 0) p3_first = c;
      @(negedge clk);
      check($sformatf("model_y[%0d]", c), {16'h0000, narma_output}, 32'(m_y));
      check($sformatf("model_bs[%0d]", c), bitstream_out, model_therm(m_y));
    end
    check("p3_first_edge", 32'(p3_first), 32'd10);

    // Partial-cycle reset mid-run: clears at once, sequence restarts.
    reset = 1'b0;
    #2;
    check("async_clr_y", {16'h0000, narma_output}, 32'h0);
    check("async_clr_bs", bitstream_out, 32'h0);
    #2;
    reset = 1'b1;
    run_vecs(1, "restart");

    // Bitstream boundaries with an injected sample value.
    force dut.y_r = 16'd1024;
    #1 check("bs_1024", bitstream_out, 32'hFFFF_FFFF);
    force dut.y_r = 16'd1023;
    #1 check("bs_1023", bitstream_out, 32'h7FFF_FFFF);
    force dut.y_r = 16'd32;
    #1 check("bs_32", bitstream_out, 32'h0000_0001);
    force dut.y_r = 16'd31;
    #1 check("bs_31", bitstream_out, 32'h0000_0000);
    release dut.y_r;

    // Saturation: a full-scale sample must clamp and never wrap.
    @(negedge clk);
    force dut.y_r = 16'hFFFF;
    @(negedge clk);
    release dut.y_r;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("sat_y[%0d]", k), {16'h0000, narma_output}, 32'h0000_FFFF);
      check($sformatf("sat_bs[%0d]", k), bitstream_out, 32'hFFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
